// File: rtl/modport_fifo_if.sv
// Byte-stream handshake between a producer/consumer pair and modport_fifo.
// master = the agent driving requests and data; slave = the FIFO itself.
interface modport_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] datain;
  logic                  wr_enb;
  logic                  wr_reg;
  logic                  rd_enb;
  logic                  rd_reg;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  full;
  logic                  empty;
  logic                  threshold;
  logic                  over_flow;
  logic                  underflow;

  modport master (
    output datain, wr_enb, wr_reg, rd_enb, rd_reg,
    input  dataout, full, empty, threshold, over_flow, underflow
  );

  modport slave (
    input  datain, wr_enb, wr_reg, rd_enb, rd_reg,
    output dataout, full, empty, threshold, over_flow, underflow
  );
endinterface

// File: rtl/modport_fifo.sv
// Single-clock FIFO with qualified write/read requests, occupancy flags and
// one-cycle overflow/underflow pulses for rejected requests.
module modport_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int THRESH     = 8
) (
  input  logic           clock,
  input  logic           resetn,
  modport_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] dataout_q;
  logic                  over_flow_q;
  logic                  underflow_q;

  logic wr_req, rd_req;
  logic wr_acc, rd_acc;
  logic full_w, empty_w;

  assign full_w  = (count == CW'(DEPTH));
  assign empty_w = (count == '0);

  assign wr_req = bus.wr_enb & bus.wr_reg;
  assign rd_req = bus.rd_enb & bus.rd_reg;
  // Acceptance uses pre-edge flags, so full+both reads and empty+both writes.
  assign wr_acc = wr_req & ~full_w;
  assign rd_acc = rd_req & ~empty_w;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dataout_q   <= '0;
      over_flow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      over_flow_q <= wr_req & full_w;
      underflow_q <= rd_req & empty_w;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + AW'(1);
        dataout_q <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a write coinciding with reset is simply dropped.
  always_ff @(posedge clock) begin
    if (resetn && wr_acc) mem[wr_ptr] <= bus.datain;
  end

  assign bus.dataout   = dataout_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.threshold = (count >= CW'(THRESH));
  assign bus.over_flow = over_flow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: reset, gating, fill/drain, errors, wrap,
// simultaneous access and mid-operation reset.
module tb_modport_fifo;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  modport_fifo_if #(.DATA_WIDTH(8)) bus ();

  modport_fifo #(.DATA_WIDTH(8), .DEPTH(16), .THRESH(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic wr, input logic re, input logic rr,
                       input logic [7:0] d);
    bus.wr_enb = we;
    bus.wr_reg = wr;
    bus.rd_enb = re;
    bus.rd_reg = rr;
    bus.datain = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    drive(1, 1, 0, 0, 8'h77);

    // reset held two cycles with a write request pending
    tick();
    tick();
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_thresh", 32'(bus.threshold), 0);
    check("rst_dataout", 32'(bus.dataout), 0);
    check("rst_ovf", 32'(bus.over_flow), 0);
    check("rst_unf", 32'(bus.underflow), 0);
    resetn = 1'b1;
    drive(0, 0, 0, 0, 8'h00);
    tick();
    drive(0, 0, 1, 1, 8'h00);
    tick();
    check("rst_nothing_stored_unf", 32'(bus.underflow), 1);
    check("rst_nothing_stored_dout", 32'(bus.dataout), 0);
    drive(0, 0, 0, 0, 8'h00);
    tick();
    check("unf_clears", 32'(bus.underflow), 0);

    // qualifier gating
    drive(1, 0, 0, 0, 8'h55);
    tick();
    check("gate_wr_enb_only", 32'(bus.empty), 1);
    drive(0, 1, 0, 0, 8'h55);
    tick();
    check("gate_wr_reg_only", 32'(bus.empty), 1);
    drive(0, 0, 1, 0, 8'h00);
    tick();
    check("gate_rd_enb_empty", 32'(bus.empty), 1);
    check("gate_rd_enb_unf", 32'(bus.underflow), 0);
    drive(0, 0, 0, 1, 8'h00);
    tick();
    check("gate_rd_reg_unf", 32'(bus.underflow), 0);
    check("gate_dout", 32'(bus.dataout), 0);

    // fill 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 8'(i + 1));
      tick();
      check("fill_thresh", 32'(bus.threshold), 32'((i + 1) >= 8));
      check("fill_full", 32'(bus.full), 32'(i == 15));
      check("fill_empty", 32'(bus.empty), 0);
    end

    // overflow while full
    drive(1, 1, 0, 0, 8'hAA);
    tick();
    check("ovf_pulse", 32'(bus.over_flow), 1);
    check("ovf_full", 32'(bus.full), 1);
    drive(0, 0, 0, 0, 8'h00);
    tick();
    check("ovf_clears", 32'(bus.over_flow), 0);
    check("ovf_still_full", 32'(bus.full), 1);

    // drain, head must be 0x01 not 0xAA
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 1, 8'h00);
      tick();
      check("drain_data", 32'(bus.dataout), 32'(i + 1));
      check("drain_empty", 32'(bus.empty), 32'(i == 15));
      check("drain_thresh", 32'(bus.threshold), 32'((15 - i) >= 8));
      check("drain_full", 32'(bus.full), 0);
    end

    // underflow for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 8'h00);
      tick();
      check("unf_pulse", 32'(bus.underflow), 1);
      check("unf_dout_hold", 32'(bus.dataout), 32'h10);
    end
    drive(0, 0, 0, 0, 8'h00);
    tick();
    check("unf_clears2", 32'(bus.underflow), 0);

    // move pointers to 10 then run simultaneous traffic across the wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 8'(8'h20 + i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 1, 8'h00);
      tick();
      check("pre_wrap_data", 32'(bus.dataout), 32'(8'h20 + i));
    end
    check("pre_wrap_empty", 32'(bus.empty), 1);
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 1, 1, 8'(8'h40 + k));
      tick();
      check("sim_empty", 32'(bus.empty), 0);
      check("sim_full", 32'(bus.full), 0);
      if (k == 0) begin
        check("sim_first_unf", 32'(bus.underflow), 1);
        check("sim_first_hold", 32'(bus.dataout), 32'h29);
      end else begin
        check("sim_unf", 32'(bus.underflow), 0);
        check("sim_data", 32'(bus.dataout), 32'(8'h40 + k - 1));
      end
    end
    drive(0, 0, 1, 1, 8'h00);
    tick();
    check("sim_last_data", 32'(bus.dataout), 32'h53);
    check("sim_last_empty", 32'(bus.empty), 1);

    // full + simultaneous read/write
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 8'(8'h80 + i));
      tick();
    end
    check("refill_full", 32'(bus.full), 1);
    drive(1, 1, 1, 1, 8'hBB);
    tick();
    check("full_rw_ovf", 32'(bus.over_flow), 1);
    check("full_rw_full", 32'(bus.full), 0);
    check("full_rw_thresh", 32'(bus.threshold), 1);
    check("full_rw_data", 32'(bus.dataout), 32'h80);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 1, 1, 8'h00);
      tick();
      check("full_rw_drain", 32'(bus.dataout), 32'(8'h80 + i));
    end
    check("full_rw_drain_empty", 32'(bus.empty), 1);

    // reset mid-operation discards data
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 8'(8'hC0 + i));
      tick();
    end
    check("mid_not_empty", 32'(bus.empty), 0);
    resetn = 1'b0;
    drive(0, 0, 1, 1, 8'h00);
    tick();
    check("mid_rst_empty", 32'(bus.empty), 1);
    check("mid_rst_dout", 32'(bus.dataout), 0);
    resetn = 1'b1;
    tick();
    check("mid_rst_unf", 32'(bus.underflow), 1);
    check("mid_rst_dout2", 32'(bus.dataout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
